vlsu_req_sched: RTL and testbench
=================================

# vlsu_req_sched

Load/store request scheduler in front of the VLSU control machine. It accepts independent load and store request streams from the dispatcher and arbitrates them round-robin into the single `vlsu_req` handshake through a one-entry registered output stage. It caps the number of in-flight store requests, exposes a store-pending flag to the request fragmenter, and implements a drain fence for memory-ordering operations.

## Interface
- `MaxOutSt`, default 4: maximum number of store requests issued to the control machine and not yet completed; must be ≥ 1.
- `vlsu_req_t`, default `logic`: request payload type, identical to the control machine's request type.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is synchronous and active-low.
- `ld_req_valid_i` in 1, `ld_req_ready_o` out 1, `ld_req_i` in `vlsu_req_t`: load request stream.
- `st_req_valid_i` in 1, `st_req_ready_o` out 1, `st_req_i` in `vlsu_req_t`: store request stream.
- `vlsu_req_valid_o` out 1, `vlsu_req_ready_i` in 1, `vlsu_req_o` out `vlsu_req_t`: to the control machine.
- `st_done_i` in 1: one-cycle pulse per fully completed store request (last B accepted).
- `st_pending_o` out 1: high while any store is buffered or outstanding.
- `fence_i` in 1: fence request, level, sampled every cycle in RUN.
- `fence_ack_o` out 1: one-cycle pulse when the fence is complete.

## Operation
- **Output buffer.** One entry holding `{payload, is_st}`.
  - The buffer can load when it is empty, or when it is being drained in the same cycle (`vlsu_req_valid_o && vlsu_req_ready_i`).
  - `vlsu_req_o` and `vlsu_req_valid_o` are driven only from the buffer, never combinationally from the inputs.
- **Store counter `cnt`.** Width `$clog2(MaxOutSt+1)`.
  - Increments when the buffer drains an entry with `is_st`.
  - Decrements on `st_done_i`.
  - If both happen in the same cycle, `cnt` is unchanged.
  - `st_done_i` while `cnt == 0` is ignored; the counter never underflows.
- **In-flight count.** `inflight = cnt + (buf_valid && buf_is_st)`.
- **Eligibility.**
  - A load is eligible when `ld_req_valid_i` is high.
  - A store is eligible when `st_req_valid_i` is high and `inflight < MaxOutSt`. Use the next-cycle value of `inflight` only if this is implemented consistently; the reference behaviour uses the current-cycle value.
- **Arbitration.**
  - Only in RUN, and only when the buffer can load.
  - If only one requester is eligible, it wins.
  - If both are eligible, the requester not granted last time wins.
  - `last_st` flag: reset value 1, so a load wins the first tie.
  - `ld_req_ready_o` / `st_req_ready_o` equal the grant, which is combinational from valid, state and buffer status.
- **State machine (`sched_state_e`).**
  - RUN: arbitration enabled. On `fence_i == 1`, grants are suppressed in that same cycle and the next state is FENCE.
  - FENCE: no grants. When `!buf_valid && cnt == 0`, pulse `fence_ack_o` for one cycle and go to RUN.
  - `fence_i` is ignored while in FENCE.
  - A fence raised while already idle acks on the cycle after entering FENCE.
- **`st_pending_o`** = `(cnt != 0) || (buf_valid && buf_is_st)`.

## Timing
- **Reset values.** State RUN, `buf_valid = 0`, `cnt = 0`, `last_st = 1`. All outputs are 0: `vlsu_req_valid_o`, both readies, `st_pending_o`, `fence_ack_o`.
- **Latency.** An input accepted in cycle N is presented on `vlsu_req_valid_o` in cycle N+1.
- **Throughput.** One request per cycle is sustained while `vlsu_req_ready_i` stays high.
- **Output stability.** Once `vlsu_req_valid_o` is asserted, `valid` and payload stay stable until accepted.
- **Reset mid-operation.** Drops the buffered entry and clears `cnt`. Completions arriving afterwards are ignored by the underflow rule.
- **Fence timing.** `fence_ack_o` is asserted no earlier than 2 cycles after `fence_i` rises.

## Structure
- Add to `vlsu_pkg`:
  - `sched_state_e` (RUN, FENCE).
  - `req_src_e` (SRC_LD, SRC_ST), used for the `is_st` encoding and arbitration.
- No sub-module. The 2-way round-robin and the one-entry buffer are inline, about 150–200 lines.

## Test plan
- **Round-robin.** Both streams continuously valid, downstream ready always. Output order is L, S, L, S, …; one request per cycle from cycle 1.
- **Store cap.** `MaxOutSt = 2`, loads idle, 5 stores, no `st_done_i`. Exactly 2 stores issue and `st_req_ready_o` stays low. One `st_done_i` pulse lets exactly one more store issue.
- **Simultaneous events.** `cnt = 1`; a store drains in the same cycle `st_done_i` pulses. `cnt` remains 1 and `st_pending_o` stays 1.
- **Backpressure.** Hold `vlsu_req_ready_i` low for 5 cycles with a buffered load. Payload and valid are stable, and both input readies are 0 throughout.
- **Fence.** With 2 stores outstanding, raise `fence_i`. No grants follow. Two `st_done_i` pulses are then sent; `fence_ack_o` pulses once, the cycle after `cnt` reaches 0, and arbitration resumes.
- **Reset and underflow.** Reset asserted with a buffered store and `cnt = 3`. The next cycle shows all outputs 0. A later `st_done_i` leaves `cnt` at 0.

Source files
------------

// File: rtl/vlsu_pkg.sv
// Shared types for the VLSU request path: scheduler state and request source.
package vlsu_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FENCE = 1'b1
  } sched_state_e;

  typedef enum logic {
    SRC_LD = 1'b0,
    SRC_ST = 1'b1
  } req_src_e;

endpackage

// File: rtl/vlsu_req_sched.sv
// Round-robin load/store request scheduler with a one-entry registered output,
// an in-flight store cap and a drain fence for memory-ordering operations.
module vlsu_req_sched
  import vlsu_pkg::*;
#(
  parameter int unsigned MaxOutSt   = 4,
  parameter type         vlsu_req_t = logic
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      ld_req_valid_i,
  output logic      ld_req_ready_o,
  input  vlsu_req_t ld_req_i,
  input  logic      st_req_valid_i,
  output logic      st_req_ready_o,
  input  vlsu_req_t st_req_i,
  output logic      vlsu_req_valid_o,
  input  logic      vlsu_req_ready_i,
  output vlsu_req_t vlsu_req_o,
  input  logic      st_done_i,
  output logic      st_pending_o,
  input  logic      fence_i,
  output logic      fence_ack_o
);

  localparam int unsigned CntW = $clog2(MaxOutSt + 1);

  sched_state_e    state_q, state_d;
  logic            buf_valid_q;
  req_src_e        buf_src_q;
  vlsu_req_t       buf_data_q;
  logic [CntW-1:0] cnt_q;
  req_src_e        last_q;
  logic            fence_ack_q;
  logic            ack_d;

  logic            drain, can_load, buf_is_st;
  logic [CntW:0]   inflight;
  logic            ld_elig, st_elig, arb_en;
  logic            gnt_ld, gnt_st;
  logic            cnt_inc, cnt_dec;

  assign drain     = buf_valid_q && vlsu_req_ready_i;
  assign can_load  = !buf_valid_q || drain;
  assign buf_is_st = buf_valid_q && (buf_src_q == SRC_ST);

  // A buffered store already counts against the cap, so granting on the
  // current inflight value can never exceed MaxOutSt next cycle.
  assign inflight = {1'b0, cnt_q} + {{CntW{1'b0}}, buf_is_st};
  assign ld_elig  = ld_req_valid_i;
  assign st_elig  = st_req_valid_i && (inflight < (CntW + 1)'(MaxOutSt));
  assign arb_en   = rst_ni && (state_q == RUN) && !fence_i && can_load;

  always_comb begin
    gnt_ld = 1'b0;
    gnt_st = 1'b0;
    if (arb_en) begin
      if (ld_elig && st_elig) begin
        if (last_q == SRC_ST) gnt_ld = 1'b1;
        else                  gnt_st = 1'b1;
      end else begin
        gnt_ld = ld_elig;
        gnt_st = st_elig;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (fence_i) state_d = FENCE;
      end
      FENCE: begin
        if (!buf_valid_q && (cnt_q == '0)) begin
          state_d = RUN;
          ack_d   = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign cnt_inc = drain && (buf_src_q == SRC_ST);
  assign cnt_dec = st_done_i && (cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      buf_valid_q <= 1'b0;
      buf_src_q   <= SRC_LD;
      buf_data_q  <= '0;
      cnt_q       <= '0;
      last_q      <= SRC_ST;
      fence_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fence_ack_q <= ack_d;
      if (gnt_ld || gnt_st) begin
        buf_valid_q <= 1'b1;
        buf_src_q   <= gnt_st ? SRC_ST : SRC_LD;
        buf_data_q  <= gnt_st ? st_req_i : ld_req_i;
        last_q      <= gnt_st ? SRC_ST : SRC_LD;
      end else if (drain) begin
        buf_valid_q <= 1'b0;
      end
      if (cnt_inc && !cnt_dec)      cnt_q <= cnt_q + 1'b1;
      else if (!cnt_inc && cnt_dec) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign ld_req_ready_o   = gnt_ld;
  assign st_req_ready_o   = gnt_st;
  assign vlsu_req_valid_o = buf_valid_q;
  assign vlsu_req_o       = buf_data_q;
  assign st_pending_o     = (cnt_q != '0) || buf_is_st;
  assign fence_ack_o      = fence_ack_q;

endmodule

// File: tb/tb_vlsu_req_sched.sv
// Directed + random bench for vlsu_req_sched against a cycle-level behavioural model.
module tb_vlsu_req_sched;

  localparam int MAX = 4;
  typedef logic [15:0] req_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ld_v, st_v, rdy_in, done, fence;
  req_t ld_d, st_d;
  logic ld_rdy, st_rdy, out_v, pend, ack;
  req_t out_d;

  always #5 clk = ~clk;

  vlsu_req_sched #(
    .MaxOutSt  (MAX),
    .vlsu_req_t(req_t)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .ld_req_valid_i  (ld_v),
    .ld_req_ready_o  (ld_rdy),
    .ld_req_i        (ld_d),
    .st_req_valid_i  (st_v),
    .st_req_ready_o  (st_rdy),
    .st_req_i        (st_d),
    .vlsu_req_valid_o(out_v),
    .vlsu_req_ready_i(rdy_in),
    .vlsu_req_o      (out_d),
    .st_done_i       (done),
    .st_pending_o    (pend),
    .fence_i         (fence),
    .fence_ack_o     (ack)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: one optional held request, a count of issued but
  // uncompleted stores, who won last, and whether a fence is draining.
  bit   m_bv, m_bst, m_last_st, m_fence, m_ack;
  req_t m_bd;
  int   m_cnt;

  logic obs_v, obs_ld_rdy, obs_st_rdy, obs_pend, obs_ack;
  req_t obs_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bv = 0; m_bst = 0; m_bd = '0; m_cnt = 0;
    m_last_st = 1; m_fence = 0; m_ack = 0;
  endtask

  task automatic step();
    bit drain, can, ld_ok, st_ok, gl, gs;
    int infl, nc;
    @(negedge clk);
    obs_v = out_v; obs_d = out_d; obs_ld_rdy = ld_rdy; obs_st_rdy = st_rdy;
    obs_pend = pend; obs_ack = ack;
    drain = m_bv && rdy_in;
    can   = !m_bv || drain;
    infl  = m_cnt + ((m_bv && m_bst) ? 1 : 0);
    ld_ok = ld_v;
    st_ok = st_v && (infl < MAX);
    gl = 0; gs = 0;
    if (rst_n && !m_fence && !fence && can) begin
      if (ld_ok && st_ok) begin
        // fairness: whichever side did not win the previous grant
        gs = !m_last_st;
        gl = m_last_st;
      end else begin
        gl = ld_ok;
        gs = st_ok;
      end
    end
    chk("out_valid", obs_v, m_bv);
    if (m_bv) chk("out_data", obs_d, m_bd);
    chk("ld_ready", obs_ld_rdy, gl);
    chk("st_ready", obs_st_rdy, gs);
    chk("st_pending", obs_pend, infl != 0);
    chk("fence_ack", obs_ack, m_ack);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      nc = m_cnt + ((drain && m_bst) ? 1 : 0) - ((done && m_cnt > 0) ? 1 : 0);
      m_ack = 0;
      if (!m_fence) begin
        if (fence) m_fence = 1;
      end else if (!m_bv && m_cnt == 0) begin
        m_fence = 0;
        m_ack = 1;
      end
      if (gl || gs) begin
        m_bv = 1; m_bst = gs; m_bd = gs ? st_d : ld_d; m_last_st = gs;
      end else if (drain) begin
        m_bv = 0;
      end
      m_cnt = nc;
    end
    #1;
  endtask

  task automatic rand_data();
    ld_d = req_t'($urandom); ld_d[15] = 1'b0;
    st_d = req_t'($urandom); st_d[15] = 1'b1;
  endtask

  task automatic idle_drain(input int n);
    ld_v = 0; st_v = 0; rdy_in = 1; fence = 0; done = 1;
    for (int i = 0; i < n; i++) step();
    done = 0;
  endtask

  initial begin
    int   n;
    req_t held;
    rst_n = 0; ld_v = 0; st_v = 0; rdy_in = 0; done = 0; fence = 0;
    ld_d = '0; st_d = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step();
    rst_n = 1;
    chk("reset_valid", obs_v, 0);
    chk("reset_pend", obs_pend, 0);
    chk("reset_ack", obs_ack, 0);

    // round-robin: L, S, L, S ... one per cycle from cycle 1
    ld_v = 1; st_v = 1; rdy_in = 1; done = 1;
    for (int k = 0; k < 12; k++) begin
      rand_data();
      step();
      if (k == 0) chk("rr_first_empty", obs_v, 0);
      else begin
        chk("rr_valid", obs_v, 1);
        chk("rr_order", obs_d[15], (k % 2 == 0) ? 1 : 0);
      end
    end
    idle_drain(4);

    // store cap
    st_v = 1; n = 0;
    for (int k = 0; k < 10; k++) begin
      rand_data();
      step();
      if (obs_st_rdy) n++;
    end
    chk("cap_issued", n, MAX);
    chk("cap_ready_low", obs_st_rdy, 0);
    done = 1; step(); done = 0;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (obs_st_rdy) n++;
    end
    chk("cap_one_more", n, 1);
    idle_drain(6);

    // store drains in the same cycle as a completion
    rand_data();
    st_v = 1; step();
    st_v = 0; step();
    st_v = 1; rand_data(); step();
    st_v = 0; done = 1; step();
    done = 0; step();
    chk("simul_pend", obs_pend, 1);
    idle_drain(3);

    // backpressure
    rdy_in = 0; ld_v = 1; st_v = 1; rand_data();
    step();
    for (int k = 0; k < 5; k++) begin
      rand_data();
      step();
      if (k == 0) held = obs_d;
      chk("bp_valid", obs_v, 1);
      chk("bp_data", obs_d, held);
      chk("bp_ld_rdy", obs_ld_rdy, 0);
      chk("bp_st_rdy", obs_st_rdy, 0);
    end
    idle_drain(6);

    // fence with two stores outstanding
    st_v = 1; rand_data(); step(); rand_data(); step();
    st_v = 0; step(); step();
    chk("fence_pend_before", obs_pend, 1);
    ld_v = 1; st_v = 1; fence = 1;
    for (int k = 0; k < 4; k++) begin
      rand_data();
      step();
      chk("fence_no_grant", obs_ld_rdy | obs_st_rdy, 0);
      chk("fence_no_ack", obs_ack, 0);
    end
    done = 1; step(); done = 0; step(); done = 1; step();
    done = 0; fence = 0;
    step();
    chk("fence_ack_early", obs_ack, 0);
    chk("fence_still_blocked", obs_ld_rdy | obs_st_rdy, 0);
    step();
    chk("fence_ack", obs_ack, 1);
    chk("fence_resume", obs_ld_rdy | obs_st_rdy, 1);
    step();
    chk("fence_ack_once", obs_ack, 0);
    idle_drain(6);

    // fence while idle: ack two cycles after raise
    fence = 1; step(); fence = 0;
    step(); chk("idle_fence_wait", obs_ack, 0);
    step(); chk("idle_fence_ack", obs_ack, 1);
    step(); chk("idle_fence_once", obs_ack, 0);

    // reset with a buffered store and cnt = 3, then a stray completion
    st_v = 1; rdy_in = 1;
    for (int k = 0; k < 4; k++) begin rand_data(); step(); end
    st_v = 0; rdy_in = 0; rst_n = 0; step();
    rst_n = 1; step();
    chk("rst_mid_valid", obs_v, 0);
    chk("rst_mid_pend", obs_pend, 0);
    chk("rst_mid_rdys", obs_ld_rdy | obs_st_rdy, 0);
    chk("rst_mid_ack", obs_ack, 0);
    done = 1; step(); done = 0; step();
    chk("underflow_pend", obs_pend, 0);
    rdy_in = 1; st_v = 1; n = 0;
    for (int k = 0; k < 8; k++) begin
      rand_data();
      step();
      if (obs_st_rdy) n++;
    end
    chk("underflow_cap", n, MAX);
    idle_drain(6);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      ld_v   = ($urandom_range(0, 99) < 60);
      st_v   = ($urandom_range(0, 99) < 60);
      rdy_in = ($urandom_range(0, 99) < 75);
      done   = ($urandom_range(0, 99) < 30);
      fence  = ($urandom_range(0, 99) < 4);
      rand_data();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
